mac_send_arbiter: RTL

Shares the single Ethernet transmit MAC between three frame sources: ARP reply, ICMP echo reply and UDP data. It grants the MAC to one requester at a time using round-robin order and passes that requester's byte stream to the MAC through one register stage. After every frame it enforces the inter-frame gap. It sits between the protocol send blocks and the MAC transmit/CRC stage, on the same byte clock as the receive path.

---
 rtl/mac_send_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mac_send_arbiter.sv
// mac_send_arbiter: round-robin share of the TX MAC among ARP/ICMP/UDP.
// Optional frame-length watchdog is built when TX_WATCHDOG_EN is defined.
module mac_send_arbiter #(
  parameter int IFG_CYCLES      = 12,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic [2:0] valid,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [2:0] grant,
  output logic       tx_enable,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       wd_abort,
  output logic [3:0] arb_state
);

  localparam logic [3:0] ST_IDLE  = 4'd1;
  localparam logic [3:0] ST_GRANT = 4'd2;
  localparam logic [3:0] ST_SEND  = 4'd4;
  localparam logic [3:0] ST_GAP   = 4'd8;

  localparam int I_IDLE  = 0;
  localparam int I_GRANT = 1;
  localparam int I_SEND  = 2;
  localparam int I_GAP   = 3;

  localparam logic [7:0] GAP_LOAD = 8'(IFG_CYCLES - 1);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [1:0] last;
  logic [1:0] last_nxt;
  logic [1:0] pick;
  logic [2:0] pick_hot;
  logic [2:0] grant_nxt;
  logic       tx_en_nxt;
  logic [7:0] tx_data_nxt;
  logic [7:0] gap_cnt;
  logic [7:0] gap_nxt;
  logic [7:0] data_g;
  logic       valid_g;
  logic       req_g;
  logic       gap_done;
  logic       wd_hit;

  assign valid_g  = |(valid & grant);
  assign req_g    = |(req & grant);
  assign data_g   = ({8{grant[0]}} & data0)
                  | ({8{grant[1]}} & data1)
                  | ({8{grant[2]}} & data2);
  assign gap_done = (gap_cnt == 8'd0);
  assign pick_hot = 3'b001 << pick;

  assign busy      = ~state[I_IDLE];
  assign arb_state = state;

  // round-robin: first requester at or after last+1 (mod 3)
  always_comb begin
    pick = last;
    case (last)
      2'd0: begin
        if (req[1])      pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else             pick = 2'd0;
      end
      2'd1: begin
        if (req[2])      pick = 2'd2;
        else if (req[0]) pick = 2'd0;
        else             pick = 2'd1;
      end
      default: begin
        if (req[0])      pick = 2'd0;
        else if (req[1]) pick = 2'd1;
        else             pick = 2'd2;
      end
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state[I_IDLE]: begin
        if (|req) state_nxt = ST_GRANT;
      end
      state[I_GRANT]: begin
        if (valid_g)     state_nxt = ST_SEND;
        else if (!req_g) state_nxt = ST_IDLE;
      end
      state[I_SEND]: begin
        if (wd_hit || !valid_g) state_nxt = ST_GAP;
      end
      state[I_GAP]: begin
        if (gap_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // next values of grant, MAC byte path and gap counter
  always_comb begin
    grant_nxt   = grant;
    last_nxt    = last;
    tx_en_nxt   = 1'b0;
    tx_data_nxt = tx_data;
    gap_nxt     = gap_cnt;
    unique case (1'b1)
      state[I_IDLE]: begin
        if (|req) begin
          grant_nxt = pick_hot;
          last_nxt  = pick;
        end
      end
      state[I_GRANT]: begin
        if (valid_g) begin
          tx_en_nxt   = 1'b1;
          tx_data_nxt = data_g;
        end else if (!req_g) begin
          grant_nxt = 3'b000;
        end
      end
      state[I_SEND]: begin
        tx_data_nxt = data_g;
        if (wd_hit || !valid_g) begin
          grant_nxt = 3'b000;
          gap_nxt   = GAP_LOAD;
        end else begin
          tx_en_nxt = 1'b1;
        end
      end
      state[I_GAP]: begin
        if (!gap_done) gap_nxt = gap_cnt - 8'd1;
      end
      default: grant_nxt = 3'b000;
    endcase
  end

  // registered outputs and arbitration history
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grant     <= 3'b000;
      last      <= 2'd2;
      tx_enable <= 1'b0;
      tx_data   <= 8'h00;
      gap_cnt   <= 8'd0;
    end else begin
      grant     <= grant_nxt;
      last      <= last_nxt;
      tx_enable <= tx_en_nxt;
      tx_data   <= tx_data_nxt;
      gap_cnt   <= gap_nxt;
    end
  end

`ifdef TX_WATCHDOG_EN
  logic [10:0] byte_cnt;

  assign wd_hit = state[I_SEND] & valid_g
                & (byte_cnt == 11'(MAX_FRAME_BYTES));

  // bytes already handed to the MAC in this frame
  always_ff @(posedge clock) begin
    if (!reset_n)       byte_cnt <= 11'd0;
    else if (tx_en_nxt) byte_cnt <= byte_cnt + 11'd1;
    else                byte_cnt <= 11'd0;
  end

  // one-cycle truncation flag
  always_ff @(posedge clock) begin
    if (!reset_n) wd_abort <= 1'b0;
    else          wd_abort <= wd_hit;
  end
`else
  // no length limit: frames of any length pass untouched
  assign wd_hit   = (MAX_FRAME_BYTES < 0);
  assign wd_abort = 1'b0;
`endif

endmodule
